multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL take one clock, clk, and one reset, rst, which is asynchronous and active-high.
REQ-002 Parameter WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  3  operation select (REQ-013).
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 result, flag_zero, flag_carry, flag_ovf, flag_err: outputs of width WIDTH, 1, 1, 1, 1, all registered.

Function
REQ-013 Op encoding SHALL be: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 SLT (signed a<b gives 1, else 0), 110 MUL (unsigned, low WIDTH bits), 111 reserved.
REQ-014 The FSM SHALL have three states: IDLE, MUL_BUSY and DONE. in_ready=1 only in IDLE.
REQ-015 A request SHALL be accepted on an edge with in_valid&&in_ready; op, a and b are captured at that edge.
REQ-016 Non-MUL ops SHALL go IDLE->DONE, with out_valid=1 on the cycle after acceptance (latency 1).
REQ-017 MUL SHALL go IDLE->MUL_BUSY and use shift-add, one multiplier bit per cycle, for WIDTH cycles, then go to DONE (out_valid WIDTH+1 cycles after acceptance).
REQ-018 In DONE, out_valid and all result/flag outputs SHALL hold stable until out_ready=1. On that edge the block returns to IDLE, and out_valid=0 on the next cycle.
REQ-019 Inputs SHALL be ignored outside IDLE; the block holds no queue (at most one request in flight).
REQ-020 flag_zero SHALL equal (result==0) for every op.
REQ-021 Carry flag: ADD gives carry-out of bit WIDTH-1; SUB gives borrow (unsigned a<b); MUL gives 1 if the upper WIDTH bits of the full product are non-zero; all other ops give 0.
REQ-022 Overflow flag: ADD/SUB give two's-complement signed overflow; MUL gives the same value as flag_carry; all other ops give 0.
REQ-023 Op 111 SHALL produce result=0, flag_err=1, all other flags 0, latency 1. flag_err SHALL be 0 for all legal ops.
REQ-024 result and flags SHALL only change on the transition into DONE.

Reset
REQ-025 While rst=1: state=IDLE, in_ready=1, out_valid=0, result=0, all flags 0, and the multiplier accumulator is cleared.
REQ-026 rst asserted mid-MUL or in DONE SHALL abort the operation; the pending result is discarded and never presented.
REQ-027 The first request SHALL be accepted on the first rising edge after rst deasserts with in_valid=1.

Configuration
REQ-028 Macro MULTICYCLE_ALU_MUL_EN defined: MUL and the MUL_BUSY state are built as specified.
REQ-029 Macro MULTICYCLE_ALU_MUL_EN undefined: no multiplier logic or MUL_BUSY state is built; op 110 behaves exactly as op 111 (result 0, flag_err=1, latency 1).

Verification (WIDTH=8)
REQ-030 ADD a=0xFF b=0x01 -> result 0x00, zero=1, carry=1, ovf=0, out_valid 1 cycle after accept.
REQ-031 SUB a=0x80 b=0x01 -> result 0x7F, carry=0, ovf=1. SUB a=0x01 b=0x02 -> result 0xFF, carry=1. SLT a=0xFF b=0x01 -> result 0x01.
REQ-032 MUL a=0x0F b=0x11 -> result 0xFF, carry=0, out_valid 9 cycles after accept. MUL a=0x10 b=0x10 -> result 0x00, zero=1, carry=ovf=1.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/flags stable, in_ready=0, and a new in_valid is ignored. Raising out_ready -> in_ready=1 the next cycle.
REQ-034 rst pulse 3 cycles into MUL -> out_valid stays 0, outputs 0, in_ready=1. A following ADD 0x02+0x03 -> 0x05.
REQ-035 Build without MULTICYCLE_ALU_MUL_EN: op 110 a=0x03 b=0x04 -> result 0x00, flag_err=1, latency 1.

Source files
------------

// File: rtl/multicycle_alu.sv
// multicycle_alu
//   Single-request ALU with a valid/ready handshake on both sides. Most ops
//   finish in one cycle. MUL is a shift-add multiplier that handles one
//   multiplier bit per cycle. Results and flags are registered, and they
//   hold in DONE until the consumer takes them.
//
//   Build option: define MULTICYCLE_ALU_MUL_EN to build the multiplier and
//   the MUL_BUSY state. Without it, op 110 is treated as reserved.
//
//   Ports
//     clk, rst          rising-edge clock, asynchronous active-high reset
//     in_valid/in_ready request handshake; op, a, b are captured on accept
//     op [2:0]          ADD SUB AND OR XOR SLT MUL reserved
//     a, b [WIDTH-1:0]  operands
//     out_valid/out_ready result handshake
//     result [WIDTH-1:0], flag_zero, flag_carry, flag_ovf, flag_err
module multicycle_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_ovf,
    output logic             flag_err
);

`ifdef MULTICYCLE_ALU_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL_BUSY = 2'd1, DONE = 2'd2} state_t;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam int CW = $clog2(WIDTH) + 1;
    logic [2*WIDTH-1:0] acc, mcand, acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               mul_last;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t state, state_next;
    logic   accept;

    // Single-cycle datapath. It only gets registered on the accept edge.
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry, alu_ovf, alu_err;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

`ifdef MULTICYCLE_ALU_MUL_EN
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign mul_last = (cnt == CW'(WIDTH - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef MULTICYCLE_ALU_MUL_EN
                    if (op == OP_MUL) state_next = MUL_BUSY;
                    else
`endif
                    state_next = DONE;
                end
            end
`ifdef MULTICYCLE_ALU_MUL_EN
            MUL_BUSY: if (mul_last) state_next = DONE;
`endif
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (op)
            3'b000: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                // Operands share a sign but the sum does not.
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            3'b001: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];  // borrow: unsigned a < b
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            3'b010: alu_res = a & b;
            3'b011: alu_res = a | b;
            3'b100: alu_res = a ^ b;
            3'b101: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            // Reserved, plus MUL when it is not built. A built MUL never
            // takes this path.
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result     <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
            flag_err   <= 1'b0;
`ifdef MULTICYCLE_ALU_MUL_EN
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
`ifdef MULTICYCLE_ALU_MUL_EN
                        if (op == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            cnt    <= '0;
                        end else
`endif
                        begin
                            result     <= alu_res;
                            flag_zero  <= (alu_res == '0);
                            flag_carry <= alu_carry;
                            flag_ovf   <= alu_ovf;
                            flag_err   <= alu_err;
                        end
                    end
                end
`ifdef MULTICYCLE_ALU_MUL_EN
                MUL_BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // The last partial product is folded in on the same edge
                    // that enters DONE.
                    if (mul_last) begin
                        result     <= acc_next[WIDTH-1:0];
                        flag_zero  <= (acc_next[WIDTH-1:0] == '0);
                        flag_carry <= |acc_next[2*WIDTH-1:WIDTH];
                        flag_ovf   <= |acc_next[2*WIDTH-1:WIDTH];
                        flag_err   <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu at WIDTH=8.
// The driver pushes the expected response for each request into a queue.
// The monitor pops one entry each time a new result is presented and compares
// it. It checks the value, the latency from accept and stability under
// backpressure.
module tb_multicycle_alu;
    localparam int W = 8;
    localparam int M = 1 << W;

    logic         clk = 0, rst = 1;
    logic         in_valid = 0, in_ready, out_valid, out_ready = 0;
    logic [2:0]   op = 0;
    logic [W-1:0] a = 0, b = 0, result;
    logic         flag_zero, flag_carry, flag_ovf, flag_err;

    multicycle_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_zero(flag_zero), .flag_carry(flag_carry),
        .flag_ovf(flag_ovf), .flag_err(flag_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W+3:0] v;   // {result, zero, carry, ovf, err}
        int           lat;
        string        name;
    } exp_t;

    exp_t q[$];
    int   total = 0, bad = 0;
    bit   hold = 0, force_hi = 0;

`ifdef MULTICYCLE_ALU_MUL_EN
    localparam bit MUL_EN = 1;
`else
    localparam bit MUL_EN = 0;
`endif

    // Reference model: plain integer arithmetic on the operand values.
    function automatic exp_t model(input int o, input int x, input int y, input string nm);
        exp_t   e;
        int     sx, sy, r, c, ov, er;
        longint t;
        logic [W-1:0] rr;
        sx = (x >= M/2) ? x - M : x;
        sy = (y >= M/2) ? y - M : y;
        r = 0; c = 0; ov = 0; er = 0; e.lat = 1;
        case (o)
            0: begin t = x + y; r = int'(t % M); c = int'(t >= M);
                     t = sx + sy; ov = int'(t > M/2-1 || t < -M/2); end
            1: begin r = (x - y + M) % M; c = int'(x < y);
                     t = sx - sy; ov = int'(t > M/2-1 || t < -M/2); end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = int'(sx < sy);
            6: if (MUL_EN) begin
                   t = longint'(x) * y; r = int'(t % M); c = int'(t >= M); ov = c; e.lat = W + 1;
               end else er = 1;
            default: er = 1;
        endcase
        rr = W'(r);
        e.v = {rr, rr == 0, c[0], ov[0], er[0]};
        e.name = nm;
        return e;
    endfunction

    function automatic void check(input string nm, input logic [W+3:0] act, input logic [W+3:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endfunction

    // out_ready generator: random unless the driver holds it low or forces it high.
    initial forever begin
        @(posedge clk); #2;
        out_ready = hold ? 1'b0 : force_hi ? 1'b1 : ($urandom_range(3) != 0);
    end

    // Monitor. It samples on the falling edge.
    int   ncyc = 0, acc_cyc = 0;
    bit   cur_valid = 0;
    exp_t cur;
    always @(negedge clk) begin
        ncyc++;
        if (rst) cur_valid = 0;
        else begin
            if (out_valid) begin
                check("in_ready_in_done", {{(W+3){1'b0}}, in_ready}, '0);
                if (!cur_valid) begin
                    cur_valid = 1;
                    if (q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_output: got %h want none", {result, flag_zero, flag_carry, flag_ovf, flag_err});
                    end else begin
                        cur = q.pop_front();
                        check({cur.name, "_val"}, {result, flag_zero, flag_carry, flag_ovf, flag_err}, cur.v);
                        check({cur.name, "_lat"}, (W+4)'(ncyc - acc_cyc), (W+4)'(cur.lat));
                    end
                end else
                    check({cur.name, "_hold"}, {result, flag_zero, flag_carry, flag_ovf, flag_err}, cur.v);
            end else cur_valid = 0;
            if (in_valid && in_ready) acc_cyc = ncyc;
        end
    end

    // Issue one request. The driver acts 1 time unit after each rising edge.
    task automatic issue(input int o, input int x, input int y, input bit push, input string nm);
        int n = 0;
        op = 3'(o); a = W'(x); b = W'(y); in_valid = 1;
        if (push) q.push_back(model(o, x, y, nm));
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) begin total++; bad++; $display("FAIL accept_timeout: got busy want ready"); end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || !in_ready) && n < 500) begin @(posedge clk); #1; n++; end
        if (n >= 500) begin total++; bad++; $display("FAIL drain_timeout: got %0d pending want 0", q.size()); end
    endtask

    initial begin
        #3;
        check("reset_state", {result, flag_zero, flag_carry, flag_ovf, flag_err, in_ready, out_valid},
              {{(W+4){1'b0}}, 2'b10});
        @(posedge clk); @(posedge clk); #1;
        rst = 0;

        // Directed vectors. The first one goes out on the first edge after reset.
        force_hi = 1;
        issue(0, 8'hFF, 8'h01, 1, "add_ff_01");
        issue(1, 8'h80, 8'h01, 1, "sub_80_01");
        issue(1, 8'h01, 8'h02, 1, "sub_01_02");
        issue(5, 8'hFF, 8'h01, 1, "slt_ff_01");
        issue(5, 8'h01, 8'hFF, 1, "slt_01_ff");
        issue(0, 8'h7F, 8'h01, 1, "add_ovf");
        issue(6, 8'h0F, 8'h11, 1, "mul_0f_11");
        issue(6, 8'h10, 8'h10, 1, "mul_10_10");
        issue(6, 8'h03, 8'h04, 1, "mul_03_04");
        issue(7, 8'h12, 8'h34, 1, "reserved");
        issue(2, 8'hF0, 8'h3C, 1, "and");
        issue(3, 8'hF0, 8'h0C, 1, "or");
        issue(4, 8'hAA, 8'hAA, 1, "xor_zero");
        wait_idle();

        // Backpressure: DONE holds while in_valid is ignored.
        hold = 1; force_hi = 0;
        @(posedge clk); #1;
        issue(0, 8'h40, 8'h41, 1, "bp_add");
        for (int i = 0; i < 20 && !out_valid; i++) begin @(posedge clk); #1; end
        for (int i = 0; i < 5; i++) begin
            op = 3'd4; a = W'($urandom); b = W'($urandom); in_valid = 1;
            @(posedge clk); #1;
            check("bp_busy", {{(W+2){1'b0}}, in_ready, out_valid}, {{(W+2){1'b0}}, 2'b01});
        end
        in_valid = 0; hold = 0; force_hi = 1;
        @(posedge clk); #1;
        check("bp_release", {{(W+2){1'b0}}, in_ready, out_valid}, {{(W+2){1'b0}}, 2'b10});
        wait_idle();

`ifdef MULTICYCLE_ALU_MUL_EN
        // Abort a MUL with a reset pulse 3 cycles into it.
        issue(6, 8'hFF, 8'hFF, 0, "mul_abort");
        @(posedge clk); #1; @(posedge clk); #1;
        rst = 1; #1;
        check("abort_state", {result, flag_zero, flag_carry, flag_ovf, flag_err, in_ready, out_valid},
              {{(W+4){1'b0}}, 2'b10});
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            check("abort_quiet", {{(W+3){1'b0}}, out_valid}, '0);
        end
        issue(0, 8'h02, 8'h03, 1, "add_after_abort");
        wait_idle();
`endif

        // Random phase with random backpressure.
        force_hi = 0;
        for (int i = 0; i < 80; i++)
            issue(int'($urandom_range(7)), int'($urandom_range(M-1)), int'($urandom_range(M-1)), 1, "rand");
        force_hi = 1;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", (W+4)'(q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
